// File: rtl/sw_affine_pe_cfg_if.sv
// PE-to-PE systolic chain: score, vertical gap, reference/query symbols and control strobes.
interface sw_affine_pe_cfg_if #(
  parameter int WIDTH = 10,
  parameter int SYM_W = 2
);
  logic signed [WIDTH-1:0] v;
  logic signed [WIDTH-1:0] f;
  logic [SYM_W-1:0]        t;
  logic [SYM_W-1:0]        s;
  logic                    store_s;
  logic                    init;

  modport master (output v, f, t, s, store_s, init);
  modport slave  (input  v, f, t, s, store_s, init);
endinterface

// File: rtl/sw_affine_pe_cfg.sv
// Smith-Waterman affine-gap PE with saturating arithmetic, runtime scoring, global stall and
// per-pass best-score tracking.
module sw_affine_pe_cfg #(
  parameter int WIDTH     = 10,
  parameter int SYM_W     = 2,
  parameter int SCORE_W   = 4,
  parameter int COL_W     = 16,
  parameter int DEF_MATCH = 2,
  parameter int DEF_MISM  = -2,
  parameter int DEF_GOPEN = -2,
  parameter int DEF_GEXT  = -1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      cfg_we,
  input  logic signed [SCORE_W-1:0] cfg_match,
  input  logic signed [SCORE_W-1:0] cfg_mism,
  input  logic signed [SCORE_W-1:0] cfg_gopen,
  input  logic signed [SCORE_W-1:0] cfg_gext,
  sw_affine_pe_cfg_if.slave         up,
  sw_affine_pe_cfg_if.master        dn,
  output logic signed [WIDTH-1:0]   max_out,
  output logic [COL_W-1:0]          max_col_out,
  output logic                      done_out
);
  localparam logic signed [WIDTH-1:0] ZERO = '0;

  logic signed [WIDTH-1:0]   v_reg, e_reg, f_reg, vd_reg, max_reg;
  logic [COL_W-1:0]          col_reg, max_col_reg;
  logic [SYM_W-1:0]          t_reg, s_reg;
  logic                      store_s_reg, init_reg, done_reg;
  logic signed [SCORE_W-1:0] match_reg, mism_reg, gopen_reg, gext_reg;

  logic signed [WIDTH-1:0]   new_e, new_f, diag, v_next;
  logic [COL_W-1:0]          col_next;
  logic                      max_upd;

  // Sum in WIDTH+1 bits; an overflow shows up as disagreeing top two bits.
  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [SCORE_W-1:0] b);
    logic signed [WIDTH:0] sum;
    sum = {a[WIDTH-1], a} + {{(WIDTH+1-SCORE_W){b[SCORE_W-1]}}, b};
    if (sum[WIDTH] != sum[WIDTH-1])
      return sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return sum[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    new_e    = smax(sat_add(v_reg, gopen_reg), sat_add(e_reg, gext_reg));
    new_f    = smax(sat_add(up.v, gopen_reg), sat_add(up.f, gext_reg));
    diag     = sat_add(vd_reg, (s_reg == up.t) ? match_reg : mism_reg);
    v_next   = smax(smax(new_e, new_f), smax(diag, ZERO));
    col_next = init_reg ? col_reg + 1'b1 : '0;
    // v_next is never negative, so at pass start the cleared max always takes it.
    max_upd  = !init_reg || (v_next > max_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg       <= '0;
      e_reg       <= '0;
      f_reg       <= '0;
      vd_reg      <= '0;
      max_reg     <= '0;
      col_reg     <= '0;
      max_col_reg <= '0;
      t_reg       <= '0;
      s_reg       <= '0;
      store_s_reg <= 1'b0;
      init_reg    <= 1'b0;
      done_reg    <= 1'b0;
      match_reg   <= SCORE_W'(DEF_MATCH);
      mism_reg    <= SCORE_W'(DEF_MISM);
      gopen_reg   <= SCORE_W'(DEF_GOPEN);
      gext_reg    <= SCORE_W'(DEF_GEXT);
    end else if (!stall) begin
      done_reg    <= init_reg && !up.init;
      t_reg       <= up.t;
      store_s_reg <= up.store_s;
      init_reg    <= up.init;
      if (up.store_s)
        s_reg <= up.s;
      if (cfg_we && !init_reg && !up.init) begin
        match_reg <= cfg_match;
        mism_reg  <= cfg_mism;
        gopen_reg <= cfg_gopen;
        gext_reg  <= cfg_gext;
      end
      if (up.init) begin
        v_reg   <= v_next;
        e_reg   <= new_e;
        f_reg   <= new_f;
        vd_reg  <= up.v;
        col_reg <= col_next;
        if (max_upd) begin
          max_reg     <= v_next;
          max_col_reg <= col_next;
        end
      end else begin
        v_reg  <= '0;
        e_reg  <= '0;
        f_reg  <= '0;
        vd_reg <= '0;
      end
    end
  end

  assign dn.v        = v_reg;
  assign dn.f        = f_reg;
  assign dn.t        = t_reg;
  assign dn.s        = s_reg;
  assign dn.store_s  = store_s_reg;
  assign dn.init     = init_reg;
  assign max_out     = max_reg;
  assign max_col_out = max_col_reg;
  // A pulse caught by a stall stays pending and shows once the array runs again.
  assign done_out    = done_reg && !stall;
endmodule
